// File: rtl/win_ctrl.sv
// win_ctrl -- runtime-programmable crop/overlay window generator.
//
// A new window is offered on the cfg_* port with a valid/ready handshake.
// The accepted window spends one cycle in a check stage, where it is
// optionally clamped to the image size. It then becomes the target. On each
// fsync the active window either jumps to the target or moves toward it by
// at most C_STEP per coordinate.
//
// Build option: define WIN_CTRL_CLAMP_EN to enable clamping to
// C_IMG_WIDTH x C_IMG_HEIGHT. Without it, the target is taken unmodified and
// clamped stays 0. The check cycle is kept in both builds, so timing is the
// same either way.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    config handshake (ready is low only in CHECK)
//   cfg_left, cfg_width      requested horizontal window (C_WBITS)
//   cfg_top, cfg_height      requested vertical window (C_HBITS)
//   fsync                    single-cycle frame-start pulse
//   left, width, top, height active window (registered)
//   pending                  a config is being checked or not yet applied
//   updated                  one-cycle pulse when the active window changed
//   clamped                  last accepted config was modified by clamping
module win_ctrl #(
   parameter int C_HBITS      = 12,
   parameter int C_WBITS      = 12,
   parameter int C_IMG_WIDTH  = 1920,
   parameter int C_IMG_HEIGHT = 1080,
   parameter int C_LEFT       = 0,
   parameter int C_TOP        = 0,
   parameter int C_WIDTH      = 320,
   parameter int C_HEIGHT     = 240,
   parameter int C_STEP       = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [C_WBITS-1:0] cfg_left,
   input  logic [C_WBITS-1:0] cfg_width,
   input  logic [C_HBITS-1:0] cfg_top,
   input  logic [C_HBITS-1:0] cfg_height,
   input  logic               fsync,
   output logic [C_WBITS-1:0] left,
   output logic [C_WBITS-1:0] width,
   output logic [C_HBITS-1:0] top,
   output logic [C_HBITS-1:0] height,
   output logic               pending,
   output logic               updated,
   output logic               clamped
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_PEND  = 2'd2
   } state_t;

   localparam logic               STEP_JUMP = (C_STEP == 32'sd0);
   localparam logic [C_WBITS:0]   STEP_W    = (C_WBITS+1)'(C_STEP);
   localparam logic [C_HBITS:0]   STEP_H    = (C_HBITS+1)'(C_STEP);
   localparam logic [C_WBITS-1:0] RST_LEFT  = C_WBITS'(C_LEFT);
   localparam logic [C_WBITS-1:0] RST_WIDTH = C_WBITS'(C_WIDTH);
   localparam logic [C_HBITS-1:0] RST_TOP   = C_HBITS'(C_TOP);
   localparam logic [C_HBITS-1:0] RST_HGT   = C_HBITS'(C_HEIGHT);

   state_t state_r, state_nxt_s;

   logic               accept_s;
   logic [C_WBITS-1:0] cfg_left_r, cfg_width_r;
   logic [C_HBITS-1:0] cfg_top_r, cfg_height_r;
   logic [C_WBITS-1:0] tgt_left_r, tgt_width_r;
   logic [C_HBITS-1:0] tgt_top_r, tgt_height_r;
   logic [C_WBITS-1:0] clp_left_s, clp_width_s;
   logic [C_HBITS-1:0] clp_top_s, clp_height_s;
   logic               clp_changed_s;
   logic [C_WBITS-1:0] nxt_left_s, nxt_width_s;
   logic [C_HBITS-1:0] nxt_top_s, nxt_height_s;
   logic               at_tgt_s;
   logic               act_changed_s;

   // One fsync step on a horizontal coordinate: the distance is taken one bit
   // wider so it never wraps, and a step never goes past the target.
   function automatic logic [C_WBITS-1:0] step_w(input logic [C_WBITS-1:0] act,
                                                 input logic [C_WBITS-1:0] tgt);
      logic [C_WBITS:0] d;
      if (tgt >= act) d = {1'b0, tgt} - {1'b0, act};
      else            d = {1'b0, act} - {1'b0, tgt};
      if (STEP_JUMP || (d <= STEP_W)) step_w = tgt;
      else if (tgt > act)              step_w = act + STEP_W[C_WBITS-1:0];
      else                             step_w = act - STEP_W[C_WBITS-1:0];
   endfunction

   // Same as step_w for the vertical coordinate width.
   function automatic logic [C_HBITS-1:0] step_h(input logic [C_HBITS-1:0] act,
                                                 input logic [C_HBITS-1:0] tgt);
      logic [C_HBITS:0] d;
      if (tgt >= act) d = {1'b0, tgt} - {1'b0, act};
      else            d = {1'b0, act} - {1'b0, tgt};
      if (STEP_JUMP || (d <= STEP_H)) step_h = tgt;
      else if (tgt > act)              step_h = act + STEP_H[C_HBITS-1:0];
      else                             step_h = act - STEP_H[C_HBITS-1:0];
   endfunction

   assign accept_s = cfg_valid && cfg_ready;

`ifdef WIN_CTRL_CLAMP_EN
   localparam logic [C_WBITS:0] IMG_W = (C_WBITS+1)'(C_IMG_WIDTH);
   localparam logic [C_HBITS:0] IMG_H = (C_HBITS+1)'(C_IMG_HEIGHT);

   logic [C_WBITS:0] cw_min_s, cw_s, cl_lim_s, cl_s;
   logic [C_HBITS:0] ch_min_s, ch_s, ct_lim_s, ct_s;

   // Size is forced into 1..image size first; the offset is then limited so
   // the window still ends inside the image.
   assign cw_min_s = ({1'b0, cfg_width_r} > IMG_W) ? IMG_W : {1'b0, cfg_width_r};
   assign cw_s     = (cw_min_s == {(C_WBITS+1){1'b0}}) ? {{C_WBITS{1'b0}}, 1'b1} : cw_min_s;
   assign cl_lim_s = IMG_W - cw_s;
   assign cl_s     = ({1'b0, cfg_left_r} > cl_lim_s) ? cl_lim_s : {1'b0, cfg_left_r};
   assign ch_min_s = ({1'b0, cfg_height_r} > IMG_H) ? IMG_H : {1'b0, cfg_height_r};
   assign ch_s     = (ch_min_s == {(C_HBITS+1){1'b0}}) ? {{C_HBITS{1'b0}}, 1'b1} : ch_min_s;
   assign ct_lim_s = IMG_H - ch_s;
   assign ct_s     = ({1'b0, cfg_top_r} > ct_lim_s) ? ct_lim_s : {1'b0, cfg_top_r};

   assign clp_left_s    = cl_s[C_WBITS-1:0];
   assign clp_width_s   = cw_s[C_WBITS-1:0];
   assign clp_top_s     = ct_s[C_HBITS-1:0];
   assign clp_height_s  = ch_s[C_HBITS-1:0];
   assign clp_changed_s = (clp_left_s != cfg_left_r) || (clp_width_s != cfg_width_r) ||
                          (clp_top_s != cfg_top_r) || (clp_height_s != cfg_height_r);
`else
   assign clp_left_s    = cfg_left_r;
   assign clp_width_s   = cfg_width_r;
   assign clp_top_s     = cfg_top_r;
   assign clp_height_s  = cfg_height_r;
   assign clp_changed_s = 1'b0;
`endif

   assign nxt_left_s    = step_w(left, tgt_left_r);
   assign nxt_width_s   = step_w(width, tgt_width_r);
   assign nxt_top_s     = step_h(top, tgt_top_r);
   assign nxt_height_s  = step_h(height, tgt_height_r);
   assign at_tgt_s      = (nxt_left_s == tgt_left_r) && (nxt_width_s == tgt_width_r) &&
                          (nxt_top_s == tgt_top_r) && (nxt_height_s == tgt_height_r);
   assign act_changed_s = (nxt_left_s != left) || (nxt_width_s != width) ||
                          (nxt_top_s != top) || (nxt_height_s != height);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_nxt_s;
   end

   // Next-state logic; a new accept always wins over settling back to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_CHECK;
            else          state_nxt_s = ST_IDLE;
         end
         ST_CHECK: state_nxt_s = ST_PEND;
         ST_PEND: begin
            if (accept_s)              state_nxt_s = ST_CHECK;
            else if (fsync && at_tgt_s) state_nxt_s = ST_IDLE;
            else                        state_nxt_s = ST_PEND;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake and status decoded from the state register only.
   always_comb begin
      cfg_ready = 1'b1;
      pending   = 1'b0;
      case (state_r)
         ST_IDLE:  begin cfg_ready = 1'b1; pending = 1'b0; end
         ST_CHECK: begin cfg_ready = 1'b0; pending = 1'b1; end
         ST_PEND:  begin cfg_ready = 1'b1; pending = 1'b1; end
         default:  begin cfg_ready = 1'b1; pending = 1'b0; end
      endcase
   end

   // Capture the offered window on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_left_r   <= RST_LEFT;
         cfg_width_r  <= RST_WIDTH;
         cfg_top_r    <= RST_TOP;
         cfg_height_r <= RST_HGT;
      end else if (accept_s) begin
         cfg_left_r   <= cfg_left;
         cfg_width_r  <= cfg_width;
         cfg_top_r    <= cfg_top;
         cfg_height_r <= cfg_height;
      end
   end

   // Register the (optionally clamped) target at the end of the check cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tgt_left_r   <= RST_LEFT;
         tgt_width_r  <= RST_WIDTH;
         tgt_top_r    <= RST_TOP;
         tgt_height_r <= RST_HGT;
         clamped      <= 1'b0;
      end else if (state_r == ST_CHECK) begin
         tgt_left_r   <= clp_left_s;
         tgt_width_r  <= clp_width_s;
         tgt_top_r    <= clp_top_s;
         tgt_height_r <= clp_height_s;
         clamped      <= clp_changed_s;
      end
   end

   // Move the active window toward the target on fsync while pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         left    <= RST_LEFT;
         width   <= RST_WIDTH;
         top     <= RST_TOP;
         height  <= RST_HGT;
         updated <= 1'b0;
      end else if ((state_r == ST_PEND) && fsync) begin
         left    <= nxt_left_s;
         width   <= nxt_width_s;
         top     <= nxt_top_s;
         height  <= nxt_height_s;
         updated <= act_changed_s;
      end else begin
         updated <= 1'b0;
      end
   end

endmodule

// File: doc/win_ctrl.md
# win_ctrl

Runtime-programmable crop/overlay window generator; the parametrised successor to the fixed-window constant source. Accepts a new window over a valid/ready config port, optionally clamps it to the image size, and applies it only at frame boundaries (fsync), moving the active window either in one jump or in bounded per-frame steps. Sits between the register/CPU interface and the window consumers (cropper, overlay, scaler), driving the same left/width/top/height outputs.

## Interface
- C_HBITS, 12, vertical coordinate width
- C_WBITS, 12, horizontal coordinate width
- C_IMG_WIDTH, 1920, image width used for clamping
- C_IMG_HEIGHT, 1080, image height used for clamping
- C_LEFT / C_TOP / C_WIDTH / C_HEIGHT, 0 / 0 / 320 / 240, reset window
- C_STEP, 0, max change per coordinate per fsync; 0 = jump directly to target
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  new window offered
- cfg_ready  out  1  window accepted when cfg_valid && cfg_ready
- cfg_left, cfg_width  in  C_WBITS  requested horizontal window
- cfg_top, cfg_height  in  C_HBITS  requested vertical window
- fsync  in  1  single-cycle frame-start pulse
- left, width  out  C_WBITS  active horizontal window
- top, height  out  C_HBITS  active vertical window
- pending  out  1  target differs from active, or config being checked
- updated  out  1  one-cycle pulse: active window changed this cycle
- clamped  out  1  last accepted config was modified by clamping

## Operation
- States: IDLE (active == target), CHECK (one cycle, clamp stage computing target), PENDING (target != active, waiting for fsync).
- cfg_ready = 1 in IDLE and PENDING, 0 in CHECK. Accept -> CHECK; CHECK -> PENDING unconditionally next cycle (target registered); PENDING -> IDLE when active reaches target after an fsync.
- Accept in PENDING replaces the target; no queue, last write wins.
- Clamp (macro enabled): w = max(1, min(cfg_width, C_IMG_WIDTH)); l = min(cfg_left, C_IMG_WIDTH - w); same for height/top with C_IMG_HEIGHT. clamped registered in CHECK: 1 if any field changed, else 0.
- On fsync in PENDING, per coordinate: d = |target - active|, compared at width+1 bits unsigned; if C_STEP == 0 or d <= C_STEP, active = target, else active moves C_STEP toward target. No wrap-around, no overshoot.
- fsync in IDLE or CHECK: no effect; a config in CHECK applies at the next fsync.
- fsync and accept in the same PENDING cycle: step toward the old target, new config enters CHECK.
- pending = (state != IDLE).

## Timing
- Reset: left/width/top/height = C_LEFT/C_WIDTH/C_TOP/C_HEIGHT, target = same, state IDLE, cfg_ready = 1, pending = 0, updated = 0, clamped = 0.
- Accept at cycle n -> pending = 1 at n+1, target valid at n+2; earliest effective fsync is cycle n+2.
- fsync at cycle m -> new outputs and updated = 1 at m+1; updated is 0 if no coordinate changed.
- All outputs registered; no combinational path from inputs to outputs except none (cfg_ready decoded from state register).
- Reset asserted mid-operation discards target and pending config; outputs return to reset window asynchronously.

## Configuration
- WIN_CTRL_CLAMP_EN defined: clamp stage as above.
- Not defined: target = cfg fields unmodified, clamped tied 0; CHECK state and its one-cycle latency remain so timing is identical.

## Test plan
- Reset -> outputs 0/320/0/240, cfg_ready = 1, pending = 0.
- C_STEP = 0: write (100,640,50,480), fsync 5 cycles later -> next cycle outputs (100,640,50,480), updated = 1, pending = 0.
- Clamp enabled: write left 1800, width 400 -> applied left 1520, width 400, clamped = 1; width 0 -> width 1.
- C_STEP = 16: active left 0, write left 40 -> after 1st/2nd/3rd fsync left = 16/32/40, pending drops after 3rd.
- Write A, then write B before fsync -> fsync applies B only; fsync in the CHECK cycle -> no change, applies at next fsync.
- Reset asserted while PENDING -> outputs back to reset window, next fsync produces no update.
